// File: rtl/vote_tally_reader_pkg.sv
// Shared types and defaults for the voting-machine tally reader.
package vote_tally_reader_pkg;

  localparam int NUM_CANDIDATES = 4;
  localparam int COUNT_W        = 8;
  localparam int IDX_W          = 2;

  localparam int unsigned PRESS_CYCLES_DEF = 12;
  localparam int unsigned GAP_CYCLES_DEF   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESS,
    ST_SAMPLE,
    ST_RELEASE,
    ST_COMPARE,
    ST_DONE
  } state_t;

  typedef logic [COUNT_W-1:0] count_t;

  // One-hot candidate select line for a given candidate index.
  function automatic logic [NUM_CANDIDATES-1:0] button_sel(input logic [IDX_W-1:0] idx);
    button_sel      = '0;
    button_sel[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/tally_max_finder.sv
// Combinational maximum search over four candidate counts: lowest index wins,
// tie flags a shared maximum.
module tally_max_finder
  import vote_tally_reader_pkg::*;
(
  input  logic [COUNT_W-1:0] count0,
  input  logic [COUNT_W-1:0] count1,
  input  logic [COUNT_W-1:0] count2,
  input  logic [COUNT_W-1:0] count3,
  output logic [IDX_W-1:0]   winner,
  output logic               tie
);

  count_t     vals [NUM_CANDIDATES];
  count_t     max_val;
  logic [2:0] hits;

  assign vals[0] = count0;
  assign vals[1] = count1;
  assign vals[2] = count2;
  assign vals[3] = count3;

  // NOTE: every variable driven here gets a value before any conditional
  // update, so no path leaves it holding state and no latch is inferred.
  always_comb begin
    max_val = vals[0];
    winner  = '0;
    hits    = '0;
    // Strict greater-than keeps the lowest index when counts are equal.
    for (int i = 1; i < NUM_CANDIDATES; i++) begin
      if (vals[i] > max_val) begin
        max_val = vals[i];
        winner  = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      if (vals[i] == max_val) hits = hits + 3'd1;
    end
    tie = (hits > 3'd1);
  end

endmodule

// File: rtl/vote_tally_reader.sv
// Steps a voting machine through display mode, pressing each candidate button
// in turn, captures the shown counts and reports the winner.
module vote_tally_reader
  import vote_tally_reader_pkg::*;
#(
  parameter int unsigned PRESS_CYCLES = PRESS_CYCLES_DEF,
  parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COUNT_W-1:0] led,
  output logic               mode,
  output logic               button1,
  output logic               button2,
  output logic               button3,
  output logic               button4,
  output logic [COUNT_W-1:0] count1,
  output logic [COUNT_W-1:0] count2,
  output logic [COUNT_W-1:0] count3,
  output logic [COUNT_W-1:0] count4,
  output logic [IDX_W-1:0]   winner,
  output logic               tie,
  output logic               busy,
  output logic               done,
  output logic               result_valid
);

  localparam int unsigned PHASE_MAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int          PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam logic [PHASE_W-1:0] PRESS_LAST = PHASE_W'(PRESS_CYCLES - 1);
  localparam logic [PHASE_W-1:0] GAP_LAST   = PHASE_W'(GAP_CYCLES - 1);

  state_t                    state, state_nx;
  logic [IDX_W-1:0]          idx, idx_nx;
  logic [PHASE_W-1:0]        phase, phase_nx;
  logic [NUM_CANDIDATES-1:0] buttons, buttons_nx;
  logic                      mode_nx, busy_nx, done_nx, valid_nx;
  logic                      load_cnt, load_result;
  count_t                    counts [NUM_CANDIDATES];
  logic [IDX_W-1:0]          winner_found;
  logic                      tie_found;

  tally_max_finder u_max_finder (
    .count0 (counts[0]),
    .count1 (counts[1]),
    .count2 (counts[2]),
    .count3 (counts[3]),
    .winner (winner_found),
    .tie    (tie_found)
  );

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    phase_nx    = phase;
    valid_nx    = result_valid;
    load_cnt    = 1'b0;
    load_result = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_PRESS;
          idx_nx   = '0;
          phase_nx = '0;
          valid_nx = 1'b0;
        end
      end
      ST_PRESS: begin
        if (phase == PRESS_LAST) begin
          state_nx = ST_SAMPLE;
          phase_nx = '0;
        end else begin
          phase_nx = phase + 1'b1;
        end
      end
      ST_SAMPLE: begin
        load_cnt = 1'b1;
        state_nx = ST_RELEASE;
        phase_nx = '0;
      end
      ST_RELEASE: begin
        if (phase == GAP_LAST) begin
          phase_nx = '0;
          if (idx == IDX_W'(NUM_CANDIDATES - 1)) begin
            state_nx = ST_COMPARE;
          end else begin
            state_nx = ST_PRESS;
            idx_nx   = idx + 1'b1;
          end
        end else begin
          phase_nx = phase + 1'b1;
        end
      end
      ST_COMPARE: begin
        load_result = 1'b1;
        state_nx    = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // Abort wins over everything except IDLE, where start has priority.
    if (abort && (state != ST_IDLE)) begin
      state_nx    = ST_IDLE;
      phase_nx    = '0;
      load_cnt    = 1'b0;
      load_result = 1'b0;
    end

    if (state_nx == ST_DONE) valid_nx = 1'b1;

    // Outputs are decoded from the next state so they register in step with it.
    mode_nx    = (state_nx inside {ST_PRESS, ST_SAMPLE, ST_RELEASE, ST_COMPARE});
    buttons_nx = (state_nx inside {ST_PRESS, ST_SAMPLE}) ? button_sel(idx_nx) : '0;
    busy_nx    = (state_nx != ST_IDLE);
    done_nx    = (state_nx == ST_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      idx          <= '0;
      phase        <= '0;
      mode         <= 1'b0;
      buttons      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      winner       <= '0;
      tie          <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      phase        <= phase_nx;
      mode         <= mode_nx;
      buttons      <= buttons_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      result_valid <= valid_nx;
      if (load_result) begin
        winner <= winner_found;
        tie    <= tie_found;
      end
    end
  end

  // NOTE: the count bank is only four bytes and must read zero after reset,
  // so it is reset like ordinary flops rather than treated as RAM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CANDIDATES; i++) counts[i] <= '0;
    end else if (load_cnt) begin
      counts[idx] <= led;
    end
  end

  assign button1 = buttons[0];
  assign button2 = buttons[1];
  assign button3 = buttons[2];
  assign button4 = buttons[3];

  assign count1 = counts[0];
  assign count2 = counts[1];
  assign count3 = counts[2];
  assign count4 = counts[3];

endmodule

// File: doc/vote_tally_reader.md
VOTE_TALLY_READER -- requirements
Module: vote_tally_reader

Interface
REQ-001 Parameter PRESS_CYCLES, default 12: cycles a candidate button is held in display mode before sampling.
REQ-002 Parameter GAP_CYCLES, default 4: cycles with all buttons low between candidates.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a full tally read; sampled only in IDLE.
REQ-006 abort  input  1  cancel a read in progress.
REQ-007 led  input  8  count shown by the voting machine for the selected candidate.
REQ-008 mode  output  1  voting machine mode: 0 = vote, 1 = display.
REQ-009 button1..button4  output  1 each  candidate select lines to the voting machine.
REQ-010 count1..count4  output  8 each  captured per-candidate counts.
REQ-011 winner  output  2  index of the highest count (0 = candidate 1).
REQ-012 tie  output  1  set when the highest count is shared by more than one candidate.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when a read completes.
REQ-015 result_valid  output  1  counts, winner and tie are from a complete, unaborted read.

Function
REQ-016 States SHALL be IDLE, PRESS, SAMPLE, RELEASE, COMPARE and DONE; all outputs SHALL be registered.
REQ-017 IDLE: mode=0, all buttons 0; start=1 SHALL move to PRESS with idx=0, clear result_valid and clear the phase counter.
REQ-018 PRESS: mode=1 and only button[idx]=1, held for exactly PRESS_CYCLES cycles, then SAMPLE.
REQ-019 SAMPLE: one cycle with button[idx] still 1; count[idx] SHALL be loaded from led on that edge.
REQ-020 RELEASE: mode=1, all buttons 0, for GAP_CYCLES cycles; then PRESS with idx+1, or COMPARE when idx=3.
REQ-021 COMPARE: one cycle; winner SHALL be the lowest index holding the maximum count; tie=1 if two or more counts equal that maximum; counts compare unsigned.
REQ-022 DONE: one cycle; done=1, result_valid set, mode=0; next state IDLE.
REQ-023 With defaults, done SHALL assert in the 70th cycle after the first PRESS cycle (4 candidates x 17 cycles, plus COMPARE, plus DONE).
REQ-024 start outside IDLE SHALL be ignored; start held high through DONE SHALL begin a new read on the first IDLE cycle.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with mode=0 and buttons 0; done SHALL NOT pulse, result_valid SHALL stay 0, and counts already captured are retained.
REQ-026 abort and start both high in IDLE: start wins; abort is ignored in IDLE.
REQ-027 idx SHALL never exceed 3; at most one button output SHALL be high in any cycle.

Reset
REQ-028 When reset=0, the block SHALL go to IDLE immediately without waiting for a clock edge; all outputs, counts, idx and the phase counter SHALL be 0.
REQ-029 Reset asserted mid-read SHALL drop mode and the buttons in the same cycle, without waiting for a clock edge.

Structure
REQ-030 Shared package: state enum, NUM_CANDIDATES=4, COUNT_W=8, and the PRESS_CYCLES and GAP_CYCLES defaults.
REQ-031 One combinational sub-module, tally_max_finder (4 x 8-bit inputs -> winner, tie), instantiated once.

Verification
REQ-032 Reset, then start with led model returning 3,1,0,5 per selected button -> counts 3,1,0,5; winner=3; tie=0; done in cycle 70; result_valid=1.
REQ-033 Counts 4,4,2,4 -> winner=0; tie=1.
REQ-034 All counts 0 -> winner=0; tie=1; all counts 0.
REQ-035 abort during candidate 3 PRESS -> next cycle mode=0, buttons 0, busy=0; no done; result_valid=0; count1 and count2 retained.
REQ-036 start pulsed repeatedly while busy -> exactly one done; start held high -> back-to-back reads, with IDLE lasting one cycle between them.
REQ-037 reset=0 asserted mid-SAMPLE -> all outputs 0 before the next clock edge.
